// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and constants for the HI/LO unit.
//   op_e     - 3-bit opcode of an operation that writes HI/LO
//   state_e  - sequencing states of hilo_unit
//   DIV_ITERS - iterations of the restoring divider (one quotient bit each)
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/hilo_div_iter.sv
// div_iter: unsigned 32-bit restoring divider, one quotient bit per cycle.
//   clk, reset   - clock, asynchronous active-high reset
//   start        - load dividend/divisor and begin DIV_ITERS iterations
//   abort        - stop an in-flight divide (result is then ignored)
//   dividend     - unsigned dividend magnitude
//   divisor      - unsigned divisor magnitude (0 yields quot=all ones, rem=dividend)
//   quot, rem    - quotient / remainder, valid once the last iteration has run
//   fin          - high in the cycle whose closing edge performs the last iteration
module div_iter
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        fin
);

    logic        running;
    logic [4:0]  cnt;
    logic [32:0] rem_r;
    logic [31:0] quot_r;
    logic [31:0] dvsr;
    logic [33:0] shifted;
    logic [33:0] diff;
    logic        borrow;

    // The quotient register doubles as the dividend shift register: its MSB
    // is shifted into the partial remainder while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_r, quot_r[31]};
        diff    = shifted - {2'b00, dvsr};
        borrow  = diff[33];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            rem_r   <= '0;
            quot_r  <= '0;
            dvsr    <= '0;
        end else if (abort) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            rem_r   <= '0;
            quot_r  <= dividend;
            dvsr    <= divisor;
        end else if (running) begin
            // Restore on borrow: keep the shifted value instead of the difference.
            rem_r  <= borrow ? shifted[32:0] : diff[32:0];
            quot_r <= {quot_r[30:0], ~borrow};
            cnt    <= cnt + 5'd1;
            if (fin) begin
                running <= 1'b0;
            end
        end
    end

    assign fin  = running && (cnt == 5'(DIV_ITERS - 1));
    assign quot = quot_r;
    assign rem  = rem_r[31:0];

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: owns the HI/LO register pair and sequences MULT/MULTU (fixed
// latency), DIV/DIVU (32-cycle restoring divide plus a sign-fix cycle) and
// MTHI/MTLO (written at the accept edge).
//   clk, reset        - clock, asynchronous active-high reset
//   op_valid, op      - HI/LO-writing operation presented by EX
//   rs_data, rt_data  - operands (rs: multiplicand/dividend/MT source)
//   op_ready          - high only in IDLE; accept = op_valid && op_ready && !flush
//   flush             - abort any in-flight operation, drop an IDLE request
//   busy              - multiply or divide in flight
//   done              - one-cycle pulse after HI/LO were written by mul/div
//   hi, lo            - current HI/LO values
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        op_ready,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] MUL_CNT_INIT = 2'(MUL_LAT - 1);

    state_e             state, state_nx;
    op_e                op_in;
    logic               accept;
    logic               is_mul, is_div, is_signed;
    logic [1:0]         mul_cnt;
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] product;
    logic               neg_q, neg_r;
    logic               div_start, div_abort, div_fin;
    logic [31:0]        div_quot, div_rem;
    logic [31:0]        dvd_mag, dvs_mag;

    // Two's-complement negate when neg is set; used both to form operand
    // magnitudes and to give the divide results their signs.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    assign op_in     = op_e'(op);
    assign accept    = op_valid && op_ready && !flush;
    assign is_mul    = (op_in == OP_MULT) || (op_in == OP_MULTU);
    assign is_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);

    assign dvd_mag   = cond_neg(rs_data, is_signed && rs_data[31]);
    assign dvs_mag   = cond_neg(rt_data, is_signed && rt_data[31]);
    assign div_start = accept && is_div;
    assign div_abort = flush && (state != ST_IDLE);

    // Operands are held sign- or zero-extended to 33 bits, so one signed
    // multiply covers both MULT and MULTU; the low 64 bits are the product.
    assign product = 64'(mul_a) * 64'(mul_b);

    div_iter u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (dvd_mag),
        .divisor  (dvs_mag),
        .quot     (div_quot),
        .rem      (div_rem),
        .fin      (div_fin)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != ST_IDLE);
        op_ready = (state == ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_nx = ST_MUL;
                end else if (accept && is_div) begin
                    state_nx = ST_DIV;
                end
            end
            ST_MUL: begin
                if (flush || (mul_cnt == 2'd0)) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_nx = ST_IDLE;
                end else if (div_fin) begin
                    state_nx = ST_FIX;
                end
            end
            ST_FIX: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            mul_cnt <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_in)
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            OP_MULT, OP_MULTU: begin
                                mul_a   <= {is_signed && rs_data[31], rs_data};
                                mul_b   <= {is_signed && rt_data[31], rt_data};
                                mul_cnt <= MUL_CNT_INIT;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Quotient truncates toward zero; remainder follows the dividend.
                                neg_q <= is_signed && (rs_data[31] ^ rt_data[31]);
                                neg_r <= is_signed && rs_data[31];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (!flush) begin
                        if (mul_cnt == 2'd0) begin
                            hi   <= product[63:32];
                            lo   <= product[31:0];
                            done <= 1'b1;
                        end else begin
                            mul_cnt <= mul_cnt - 2'd1;
                        end
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        lo   <= cond_neg(div_quot, neg_q);
                        hi   <= cond_neg(div_rem, neg_r);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
